// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access size encoding, FSM states
// and the load-extension helper used by the lane aligner.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_RSVD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int unsigned WAIT_W = 4;

    function automatic logic [31:0] extend_lane(input logic [15:0] lane,
                                                input logic        is_half,
                                                input logic        is_unsigned);
        logic fill;
        if (is_unsigned) begin
            fill = 1'b0;
        end else if (is_half) begin
            fill = lane[15];
        end else begin
            fill = lane[7];
        end
        if (is_half) begin
            return {{16{fill}}, lane};
        end else begin
            return {{24{fill}}, lane[7:0]};
        end
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/halfword/word lane steering: store byte mask and replicated write word,
// plus extraction and sign/zero extension of load data from the stored word.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  size_e       size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [7:0]  byte_lane_s;
    logic [15:0] half_lane_s;

    // Lane selection and extension for every access size
    always_comb begin
        byte_lane_s = rword[{addr_lo, 3'b000} +: 8];
        half_lane_s = addr_lo[1] ? rword[31:16] : rword[15:0];
        wmask       = 4'b1111;
        wword       = wdata;
        rdata       = rword;
        case (size)
            SZ_BYTE: begin
                wmask = 4'b0001 << addr_lo;
                wword = {4{wdata[7:0]}};
                rdata = extend_lane({8'h00, byte_lane_s}, 1'b0, is_unsigned);
            end
            SZ_HALF: begin
                wmask = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
                rdata = extend_lane(half_lane_s, 1'b1, is_unsigned);
            end
            SZ_WORD, SZ_RSVD: begin
                wmask = 4'b1111;
                wword = wdata;
                rdata = rword;
            end
            default: begin
                wmask = 4'b1111;
                wword = wdata;
                rdata = rword;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: single-outstanding load/store with WAIT_CYCLES wait states.
// Optional access-error checking is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

    state_e             state_q,     state_d;
    logic [WAIT_W-1:0]  cnt_q,       cnt_d;
    logic               we_q,        we_d;
    logic [AW+1:0]      addr_q,      addr_d;
    logic [31:0]        wdata_q,     wdata_d;
    size_e              size_q,      size_d;
    logic               uns_q,       uns_d;
    logic               err_q,       err_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [31:0]        rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q,   rsp_err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept_s;
    logic        commit_s;
    logic        mem_we_s;
    logic        req_err_s;
    logic [3:0]  wmask_s;
    logic [31:0] wword_s;
    logic [31:0] rword_s;
    logic [31:0] rdata_s;

`ifdef DMEM_ERR_CHECK_EN
    // Access legality is judged on the raw request so the verdict travels with it
    always_comb begin
        case (size_e'(req_size))
            SZ_BYTE: req_err_s = 1'b0;
            SZ_HALF: req_err_s = req_addr[0];
            SZ_WORD: req_err_s = |req_addr[1:0];
            SZ_RSVD: req_err_s = 1'b1;
            default: req_err_s = 1'b1;
        endcase
        if (|req_addr[31:AW+2]) begin
            req_err_s = 1'b1;
        end else begin
            req_err_s = req_err_s;
        end
    end
`else
    logic unused_addr_s;
    assign req_err_s     = 1'b0;
    assign unused_addr_s = ^req_addr[31:AW+2];
`endif

    assign accept_s = req_valid && req_ready_q;
    assign commit_s = (state_q == S_WAIT) && (cnt_q == '0);
    assign mem_we_s = commit_s && we_q && !err_q;
    assign rword_s  = mem_q[addr_q[AW+1:2]];

    dmem_lane_align u_lane_align (
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .rword       (rword_s),
        .wmask       (wmask_s),
        .wword       (wword_s),
        .rdata       (rdata_s)
    );

    // Next-state and registered-output logic for the request/response FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        err_d       = err_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    we_d        = req_we;
                    addr_d      = req_addr[AW+1:0];
                    wdata_d     = req_wdata;
                    size_d      = size_e'(req_size);
                    uns_d       = req_unsigned;
                    err_d       = req_err_s;
                    cnt_d       = WAIT_INIT;
                    state_d     = S_WAIT;
                    req_ready_d = 1'b0;
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_WAIT: begin
                if (commit_s) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = (we_q || err_q) ? 32'h0000_0000 : rdata_s;
                end else begin
                    cnt_d = cnt_q - {{(WAIT_W-1){1'b0}}, 1'b1};
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0000_0000;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b0;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = 32'h0000_0000;
                rsp_err_d   = 1'b0;
            end
        endcase
    end

    // Control and response registers; reset discards any pending request
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= 32'h0000_0000;
            size_q      <= SZ_BYTE;
            uns_q       <= 1'b0;
            err_q       <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Storage write at the commit edge; only masked byte lanes change
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_s[b]) begin
                    mem_q[addr_q[AW+1:2]][8*b +: 8] <= wword_s[8*b +: 8];
                end
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait state, one with three.
module tb_dmem_responder;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [1:0]  req_size = 2'd2;
    logic        req_unsigned = 1'b0;
    logic        rsp_ready = 1'b1;
    logic        valid1 = 1'b0;
    logic        valid3 = 1'b0;
    logic        ready1, rv1, err1, ready3, rv3, err3;
    logic [31:0] rd1, rd3;
    logic        sel = 1'b0;
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut1 (
        .clock(clock), .resetn(resetn), .req_valid(valid1), .req_ready(ready1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .rsp_valid(rv1), .rsp_ready(rsp_ready),
        .rsp_rdata(rd1), .rsp_err(err1)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut3 (
        .clock(clock), .resetn(resetn), .req_valid(valid3), .req_ready(ready3),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned), .rsp_valid(rv3), .rsp_ready(rsp_ready),
        .rsp_rdata(rd3), .rsp_err(err3)
    );

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel) valid3 = v;
        else     valid1 = v;
    endtask

    // Full request/response handshake with rsp_ready held high.
    task automatic transact(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                            input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err);
        int n;
        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size; req_unsigned = uns;
        set_valid(1'b1);
        n = 0;
        while ((sel ? ready3 : ready1) !== 1'b1 && n < 50) begin
            @(posedge clock); #1; n++;
        end
        check32({tag, "_ready"}, {31'd0, (sel ? ready3 : ready1)}, 32'd1);
        @(posedge clock); #1;
        set_valid(1'b0);
        n = 0;
        while ((sel ? rv3 : rv1) !== 1'b1 && n < 50) begin
            @(posedge clock); #1; n++;
        end
        check32({tag, "_lat"}, n, exp_lat);
        check32({tag, "_rdata"}, sel ? rd3 : rd1, exp_rdata);
        check32({tag, "_err"}, {31'd0, (sel ? err3 : err1)}, {31'd0, exp_err});
        @(posedge clock); #1;
        check32({tag, "_vdrop"}, {31'd0, (sel ? rv3 : rv1)}, 32'd0);
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check32("rst_ready1", {31'd0, ready1}, 32'd0);
        check32("rst_valid1", {31'd0, rv1}, 32'd0);
        check32("rst_rdata1", rd1, 32'h0);
        check32("rst_err1", {31'd0, err1}, 32'd0);
        @(negedge clock); resetn = 1'b1;
        @(posedge clock); #1;
        check32("rel_ready1", {31'd0, ready1}, 32'd1);
        check32("rel_ready3", {31'd0, ready3}, 32'd1);

        // Word store/load and extension
        sel = 1'b0;
        transact("t1_sw",   1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 2, 32'h0, 1'b0);
        transact("t1_lw",   1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 2, 32'hDEADBEEF, 1'b0);
        transact("t2_lb",   1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 2, 32'hFFFFFFDE, 1'b0);
        transact("t2_lbu",  1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 2, 32'h000000DE, 1'b0);
        transact("t2_lh",   1'b0, 32'h100, 32'h0, 2'd1, 1'b0, 2, 32'hFFFFBEEF, 1'b0);
        transact("t2_lhu",  1'b0, 32'h102, 32'h0, 2'd1, 1'b1, 2, 32'h0000DEAD, 1'b0);

        // Partial stores preserve the other lanes
        transact("t3_sb",   1'b1, 32'h101, 32'hFFFFFF55, 2'd0, 1'b0, 2, 32'h0, 1'b0);
        transact("t3_lw1",  1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 2, 32'hDEAD55EF, 1'b0);
        transact("t3_sh",   1'b1, 32'h102, 32'hFFFF1234, 2'd1, 1'b0, 2, 32'h0, 1'b0);
        transact("t3_lw2",  1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 2, 32'h123455EF, 1'b0);
        transact("t3_lb",   1'b0, 32'h101, 32'h0, 2'd0, 1'b0, 2, 32'h00000055, 1'b0);
        transact("t3_lh",   1'b0, 32'h102, 32'h0, 2'd1, 1'b0, 2, 32'h00001234, 1'b0);

        // Backpressure: response held, stray request ignored
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 32'h100; req_size = 2'd2; req_unsigned = 1'b0;
        valid1 = 1'b1;
        @(posedge clock); #1;
        valid1 = 1'b0;
        n = 0;
        while (rv1 !== 1'b1 && n < 50) begin
            @(posedge clock); #1; n++;
        end
        check32("t4_lat", n, 2);
        for (int i = 0; i < 5; i++) begin
            check32("t4_hold_valid", {31'd0, rv1}, 32'd1);
            check32("t4_hold_rdata", rd1, 32'h123455EF);
            check32("t4_hold_ready", {31'd0, ready1}, 32'd0);
            if (i == 1) begin
                req_we = 1'b1; req_wdata = 32'hFFFFFFFF; valid1 = 1'b1;
            end else begin
                valid1 = 1'b0;
            end
            @(posedge clock); #1;
        end
        valid1 = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        check32("t4_drop_valid", {31'd0, rv1}, 32'd0);
        check32("t4_ready_back", {31'd0, ready1}, 32'd1);
        transact("t4_lw",   1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 2, 32'h123455EF, 1'b0);

        // Reset mid-operation on the three-wait-state instance
        sel = 1'b1;
        transact("t5_pre",  1'b1, 32'h200, 32'h11111111, 2'd2, 1'b0, 4, 32'h0, 1'b0);
        req_we = 1'b1; req_addr = 32'h200; req_wdata = 32'hAAAAAAAA; req_size = 2'd2;
        valid3 = 1'b1;
        @(posedge clock); #1;
        valid3 = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b0;
        #1;
        check32("t5_rst_valid", {31'd0, rv3}, 32'd0);
        check32("t5_rst_ready", {31'd0, ready3}, 32'd0);
        repeat (4) @(posedge clock);
        #1;
        check32("t5_rst_valid2", {31'd0, rv3}, 32'd0);
        check32("t5_rst_ready2", {31'd0, ready3}, 32'd0);
        @(negedge clock); resetn = 1'b1;
        @(posedge clock); #1;
        check32("t5_rel_ready", {31'd0, ready3}, 32'd1);
        transact("t5_lw",   1'b0, 32'h200, 32'h0, 2'd2, 1'b0, 4, 32'h11111111, 1'b0);

        // Out-of-range and misaligned accesses
        sel = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
        transact("t6_sw0",  1'b1, 32'h0, 32'h01020304, 2'd2, 1'b0, 2, 32'h0, 1'b0);
        transact("t6_mis",  1'b0, 32'h102, 32'h0, 2'd2, 1'b0, 2, 32'h0, 1'b1);
        transact("t6_mish", 1'b0, 32'h101, 32'h0, 2'd1, 1'b0, 2, 32'h0, 1'b1);
        transact("t6_rsvd", 1'b0, 32'h100, 32'h0, 2'd3, 1'b0, 2, 32'h0, 1'b1);
        transact("t6_oor",  1'b1, 32'h1000, 32'hCAFEF00D, 2'd2, 1'b0, 2, 32'h0, 1'b1);
        transact("t6_lw0",  1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 2, 32'h01020304, 1'b0);
`else
        transact("t6_wrap", 1'b1, 32'h1000, 32'hCAFEF00D, 2'd2, 1'b0, 2, 32'h0, 1'b0);
        transact("t6_lw0",  1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 2, 32'hCAFEF00D, 1'b0);
        transact("t6_rsvd", 1'b0, 32'h0, 32'h0, 2'd3, 1'b0, 2, 32'hCAFEF00D, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
